ahb_matrix_decoder_param: RTL
=============================

Name: ahb_matrix_decoder_param

Overview:
Parametrised bus-matrix input-side decoder, the successor to the fixed two-port decoders.
- Takes one AHB input stage and decodes the address against a table of NUM_PORTS base/mask regions, plus an optional remap alias.
- Drives one-hot output-stage selects and multiplexes the data-phase response back.
- Contains its own two-cycle ERROR default slave, and a sticky fault-capture register with a saturating fault counter for firmware debug.

Parameters:
NUM_PORTS, 4, number of output stages (1..8).
REGION_BASE, {NUM_PORTS{32'h0}}, packed 32-bit base per port; port i at bits [32i+31:32i].
REGION_MASK, {NUM_PORTS{32'hFFFF_FC00}}, packed 32-bit compare mask per port; bits [9:0] always ignored.
REMAP_EN, 1, enables the remap alias region.
REMAP_BASE, 32'h0000_0000, base of the alias region.
REMAP_MASK, 32'hFFFE_0000, mask of the alias region.
REMAP_PORT, 0, port index the alias region routes to.

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
remap  in  1  remap control; alias region active when 1
hreadys  in  1  input-stage HREADY
sel  in  1  input-stage HSEL
haddr  in  32  input-stage address
htrans  in  2  input-stage HTRANS
active_i  in  NUM_PORTS  per-port output-stage active
readyout_i  in  NUM_PORTS  per-port HREADYOUT
resp_i  in  2*NUM_PORTS  per-port HRESP[1:0]
rdata_i  in  32*NUM_PORTS  per-port HRDATA
sel_o  out  NUM_PORTS  one-hot per-port HSEL
active_o  out  1  active of the addressed port
hreadyout  out  1  muxed HREADYOUT
hresp  out  2  muxed HRESP; 2'b00 OKAY, 2'b01 ERROR
hrdata  out  32  muxed HRDATA
fault_clr  in  1  clears the fault register and counter
fault_valid  out  1  sticky unmapped-access flag
fault_addr  out  32  address of the first unmapped access
fault_cnt  out  8  count of unmapped accesses, saturating

Behaviour:
Interface:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: data_port=0 (no port); dslv state IDLE; fault_valid=0; fault_addr=0; fault_cnt=0.
- Out of reset: hreadyout=1, hresp=OKAY, hrdata=0; sel_o=0 whenever sel=0.

Address phase (combinational):
- Hit_i = (haddr & REGION_MASK_i) == (REGION_BASE_i & REGION_MASK_i).
- Alias hit = REMAP_EN & remap & ((haddr & REMAP_MASK) == (REMAP_BASE & REMAP_MASK)).
- Priority: alias hit first, routing to REMAP_PORT; then lowest i with Hit_i; otherwise the default slave.
- addr_port is one-hot, NUM_PORTS+1 bits; bit NUM_PORTS is the default slave.
- IDLE hold: if htrans==IDLE and data_port names a real port, addr_port = data_port, so the port is not re-arbitrated.
- sel_o = sel ? addr_port[NUM_PORTS-1:0] : 0.
- active_o = active_i of the selected port; 1 when the default slave is selected.

Data phase:
- data_port <= addr_port when hreadys=1; otherwise it holds.
- hreadyout, hresp and hrdata are muxed from data_port.
- Default slave: hrdata=0, readyout and resp come from the dslv FSM.
- data_port==0: hreadyout=1, hresp=OKAY, hrdata=0.

Default slave FSM (IDLE, ERR1, ERR2):
- Entry: hreadys & sel & default selected & htrans[1]==1 (NONSEQ/SEQ) moves to ERR1.
- ERR1: readyout=0, resp=ERROR; always goes to ERR2.
- ERR2: readyout=1, resp=ERROR; goes to ERR1 if the entry condition holds again, else to IDLE.
- IDLE: readyout=1, resp=OKAY; IDLE/BUSY transfers to the default slave complete zero-wait OKAY.

Fault capture:
- Event = the FSM entry condition above.
- Event with fault_valid=0: latch fault_addr=haddr and set fault_valid. Later events leave fault_addr unchanged.
- fault_cnt increments on each event and saturates at 255.
- fault_clr alone: fault_valid=0, fault_cnt=0; fault_addr is retained.
- fault_clr and event in the same cycle: the event wins; fault_valid=1, fault_addr=haddr, fault_cnt=1.

Reset asserted mid-transfer: all state returns to reset values immediately.

Test Plan:
- NUM_PORTS=3, regions 0x3000_0000/mask 0xE000_0000 and 0x8000_0000/mask 0xE000_0000; NONSEQ to 0x8000_0010 -> sel_o=3'b010; next cycle hrdata=rdata_i port1, hresp=resp_i port1.
- remap=1, NONSEQ to 0x0000_0100 -> sel_o selects REMAP_PORT; remap=0, same address -> default slave, hreadyout 0 then 1, hresp=01 on both cycles.
- Back-to-back NONSEQ to unmapped 0xF000_0000 and 0xF000_0004 -> FSM ERR1,ERR2,ERR1,ERR2; fault_addr=0xF000_0000; fault_cnt=2.
- IDLE with haddr unmapped after a port2 transfer -> sel_o keeps port2 selected; hreadyout follows readyout_i[2]; no fault recorded.
- 300 unmapped NONSEQs -> fault_cnt=255; fault_clr in the same cycle as a new event -> fault_valid=1, fault_cnt=1, fault_addr=new haddr.
- HRESETn low during ERR1 -> hreadyout=1, hresp=OKAY, fault_valid=0, data_port=0 on the same edge.

Source files
------------

// File: rtl/ahb_matrix_decoder_param_if.sv
// Input-stage AHB signals plus the per-port output-stage bundle of the matrix decoder.
// master drives the address phase and the output-stage responses; slave is the decoder.
interface ahb_matrix_decoder_param_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic                      hreadys;
    logic                      sel;
    logic [31:0]               haddr;
    logic [1:0]                htrans;
    logic [NUM_PORTS-1:0]      active_i;
    logic [NUM_PORTS-1:0]      readyout_i;
    logic [2*NUM_PORTS-1:0]    resp_i;
    logic [32*NUM_PORTS-1:0]   rdata_i;
    logic [NUM_PORTS-1:0]      sel_o;
    logic                      active_o;
    logic                      hreadyout;
    logic [1:0]                hresp;
    logic [31:0]               hrdata;

    modport master (
        output hreadys, sel, haddr, htrans, active_i, readyout_i, resp_i, rdata_i,
        input  sel_o, active_o, hreadyout, hresp, hrdata
    );

    modport slave (
        input  hreadys, sel, haddr, htrans, active_i, readyout_i, resp_i, rdata_i,
        output sel_o, active_o, hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_matrix_decoder_param.sv
// Bus-matrix input-side decoder: base/mask region table with remap alias, response mux,
// two-cycle ERROR default slave and sticky fault capture with a saturating counter.
module ahb_matrix_decoder_param #(
    parameter int unsigned               NUM_PORTS   = 4,
    parameter logic [32*NUM_PORTS-1:0]   REGION_BASE = {NUM_PORTS{32'h0}},
    parameter logic [32*NUM_PORTS-1:0]   REGION_MASK = {NUM_PORTS{32'hFFFF_FC00}},
    parameter bit                        REMAP_EN    = 1'b1,
    parameter logic [31:0]               REMAP_BASE  = 32'h0000_0000,
    parameter logic [31:0]               REMAP_MASK  = 32'hFFFE_0000,
    parameter int unsigned               REMAP_PORT  = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         remap,
    input  logic                         fault_clr,
    ahb_matrix_decoder_param_if.slave    bus,
    output logic                         fault_valid,
    output logic [31:0]                  fault_addr,
    output logic [7:0]                   fault_cnt
);
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} dslv_state_e;

    localparam logic [31:0] PAGE_MASK = 32'hFFFF_FC00;

    dslv_state_e            state_q, state_d;
    logic [NUM_PORTS:0]     data_port_q, data_port_d;
    logic [NUM_PORTS:0]     addr_port;
    logic                   alias_hit, found;
    logic                   dslv_entry;
    logic                   dslv_ready;
    logic [1:0]             dslv_resp;
    logic                   fault_valid_q, fault_valid_d;
    logic [31:0]            fault_addr_q, fault_addr_d;
    logic [7:0]             fault_cnt_q, fault_cnt_d;

    // Address decode; an IDLE beat keeps the port owning the data phase selected.
    always_comb begin
        addr_port = '0;
        found     = 1'b0;
        alias_hit = REMAP_EN && remap &&
                    ((bus.haddr & REMAP_MASK) == (REMAP_BASE & REMAP_MASK));
        if (alias_hit) begin
            addr_port[REMAP_PORT] = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!found && ((bus.haddr & REGION_MASK[32*i +: 32] & PAGE_MASK) ==
                               (REGION_BASE[32*i +: 32] & REGION_MASK[32*i +: 32] & PAGE_MASK))) begin
                    addr_port[i] = 1'b1;
                    found        = 1'b1;
                end
            end
            if (!found) addr_port[NUM_PORTS] = 1'b1;
        end
        if (bus.htrans == 2'b00 && |data_port_q[NUM_PORTS-1:0]) addr_port = data_port_q;
    end

    assign bus.sel_o    = bus.sel ? addr_port[NUM_PORTS-1:0] : '0;
    assign bus.active_o = |(addr_port[NUM_PORTS-1:0] & bus.active_i) | addr_port[NUM_PORTS];
    assign dslv_entry   = bus.hreadys & bus.sel & addr_port[NUM_PORTS] & bus.htrans[1];
    assign data_port_d  = bus.hreadys ? addr_port : data_port_q;

    always_comb begin
        state_d    = state_q;
        dslv_ready = 1'b1;
        dslv_resp  = 2'b00;
        unique case (state_q)
            DS_IDLE: if (dslv_entry) state_d = DS_ERR1;
            DS_ERR1: begin
                dslv_ready = 1'b0;
                dslv_resp  = 2'b01;
                state_d    = DS_ERR2;
            end
            DS_ERR2: begin
                dslv_resp = 2'b01;
                state_d   = dslv_entry ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        bus.hreadyout = 1'b1;
        bus.hresp     = 2'b00;
        bus.hrdata    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (data_port_q[i]) begin
                bus.hreadyout = bus.readyout_i[i];
                bus.hresp     = bus.resp_i[2*i +: 2];
                bus.hrdata    = bus.rdata_i[32*i +: 32];
            end
        end
        if (data_port_q[NUM_PORTS]) begin
            bus.hreadyout = dslv_ready;
            bus.hresp     = dslv_resp;
        end
    end

    // A fault event overrides a simultaneous clear and restarts capture from it.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_cnt_d   = fault_cnt_q;
        if (fault_clr) begin
            fault_valid_d = 1'b0;
            fault_cnt_d   = '0;
        end
        if (dslv_entry) begin
            fault_valid_d = 1'b1;
            if (!fault_valid_q || fault_clr) fault_addr_d = bus.haddr;
            if (fault_clr)                   fault_cnt_d  = 8'd1;
            else if (fault_cnt_q != 8'hFF)   fault_cnt_d  = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= DS_IDLE;
            data_port_q   <= '0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            data_port_q   <= data_port_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cnt   = fault_cnt_q;
endmodule
